// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
// Contents: access-size codes, FSM state codes, wait counter width and
// the latched-request record used by the top level.
package dmem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam int CNT_W = 4;
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sign;
      logic [31:0] wdata;
   } req_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-port bundle between a load/store initiator and the memory.
// master: drives req, we, size, sign, addr, wdata; receives ack, rdata, err, busy.
// slave:  the memory side, the mirror image of master.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        err;
   logic        busy;
   modport master (output req, we, size, sign, addr, wdata, input ack, rdata, err, busy);
   modport slave (input req, we, size, sign, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for one aligned 32-bit RAM word.
// Inputs:  lane (addr[1:0]), size, sign, wdata (right-aligned store data),
//          rword (the RAM word containing the access, byte 0 in [7:0]).
// Outputs: be (byte-lane write enables), wword (store data moved onto its lanes),
//          rdata (extracted and extended load data, 0 when rejected),
//          misaligned (access rejected: bad alignment or reserved size).
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misaligned
);
   logic [31:0] sh;
   always_comb begin
      misaligned = (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00) || size == SZ_RSVD;
      be = misaligned ? 4'b0000 : (size == SZ_BYTE ? 4'b0001 : size == SZ_HALF ? 4'b0011 : 4'b1111) << lane;
      wword = wdata << {lane, 3'b000};
      sh = rword >> {lane, 3'b000};
      rdata = misaligned ? 32'h0 :
              size == SZ_BYTE ? {{24{sign & sh[7]}}, sh[7:0]} :
              size == SZ_HALF ? {{16{sign & sh[15]}}, sh[15:0]} : sh;
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle byte-addressable little-endian data RAM behind a req/ack port.
// Ports: clk, rst (asynchronous, active-high), bus (dmem_responder_if.slave).
// Parameters: ADDR_WIDTH (log2 RAM bytes, addresses wrap), WAIT_STATES (0..15).
// A request is latched in IDLE, waits WAIT_STATES+1 cycles, then a one-cycle RESP
// carries ack with registered rdata/err.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   req_t                  rq_q, rq_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  wr_en;
   logic [3:0]            be;
   logic [31:0]           wword, rword, ld_data;
   logic                  misaligned;
   logic [7:0]            mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-3:0] widx;
   logic                  unused_addr;
   assign unused_addr = &{1'b0, bus.addr[31:ADDR_WIDTH]};
   // Legal accesses never cross a word, so all lanes live in the word at widx.
   assign widx = addr_q[ADDR_WIDTH-1:2];
   always_comb begin
      rword = '0;
      for (int i = 0; i < 4; i++) rword[8*i +: 8] = mem[{widx, 2'(i)}];
   end
   dmem_lane_align u_align (
      .lane       (addr_q[1:0]),
      .size       (rq_q.size),
      .sign       (rq_q.sign),
      .wdata      (rq_q.wdata),
      .rword      (rword),
      .be         (be),
      .wword      (wword),
      .rdata      (ld_data),
      .misaligned (misaligned)
   );
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rq_d    = rq_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      if (state_q == ST_IDLE && bus.req) begin
         state_d = ST_WAIT;
         cnt_d   = CNT_W'(WAIT_STATES);
         rq_d    = '{we: bus.we, size: bus.size, sign: bus.sign, wdata: bus.wdata};
         addr_d  = bus.addr[ADDR_WIDTH-1:0];
      end else if (state_q == ST_WAIT && cnt_q == '0) begin
         state_d = ST_RESP;
         err_d   = misaligned;
         rdata_d = rq_q.we ? 32'h0 : ld_data;
         wr_en   = rq_q.we & ~misaligned;
      end else if (state_q == ST_WAIT) begin
         cnt_d = cnt_q - 1'b1;
      end else if (state_q == ST_RESP) begin
         state_d = ST_IDLE;
         rdata_d = 32'h0;
         err_d   = 1'b0;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rq_q    <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rq_q    <= rq_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // RAM is not reset; an asserted rst holds the FSM in IDLE so wr_en stays low.
   always_ff @(posedge clk) begin
      if (wr_en)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[{widx, 2'(i)}] <= wword[8*i +: 8];
   end
   assign bus.ack   = state_q == ST_RESP;
   assign bus.busy  = state_q != ST_IDLE;
   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder answering the processor's load/store port with a req/ack handshake. It holds a byte-addressable little-endian RAM and serves byte, halfword and word accesses, with zero or sign extension on loads. Accesses complete after a configurable number of wait states. It is the memory-side end of the CPU data interface and replaces the single-cycle combinational data memory once the core stalls on `ack`.

## Interface
- `ADDR_WIDTH`, default 10: log2 of RAM size in bytes. Address bits above `ADDR_WIDTH-1` are ignored, so addresses wrap.
- `WAIT_STATES`, default 2: cycles spent in WAIT. Legal range 0..15.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req`  in  1: access request; held by the initiator until `ack`.
- `we`  in  1: 1 = store, 0 = load.
- `size`  in  2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sign`  in  1: for loads, 1 = sign-extend, 0 = zero-extend. Ignored for stores.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `ack`  out  1: one-cycle completion pulse.
- `rdata`  out  32: load result. Valid while `ack`=1; 0 otherwise.
- `err`  out  1: high with `ack` when the access was rejected.
- `busy`  out  1: high while in WAIT or RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE -> WAIT on an edge with `req`=1.
  - `we`, `size`, `sign`, `addr` and `wdata` are latched on that edge.
  - Later changes to the inputs are ignored.
- WAIT holds a 4-bit down-counter loaded with `WAIT_STATES`.
  - WAIT -> RESP on the edge where the counter is 0.
  - If `WAIT_STATES`=0, WAIT lasts exactly one cycle.
- RESP -> IDLE unconditionally. `ack`=1 only in RESP.
- Alignment check, performed on the latched request:
  - half access with `addr[0]`=1 is misaligned;
  - word access with `addr[1:0]`≠00 is misaligned;
  - `size`=11 is illegal.
  - Any of these gives an error response: `err`=1, `rdata`=0, memory unchanged.
- Store commit: on the WAIT -> RESP edge, write byte lanes `addr[1:0]`, +1, +2, +3 as needed.
  - Byte order is little-endian: `wdata[7:0]` goes to the lowest address.
- Load: `rdata` is registered on the WAIT -> RESP edge.
  - Byte: `mem[a]`.
  - Half: `{mem[a+1], mem[a]}`.
  - Word: `{mem[a+3] .. mem[a]}`.
  - Extended to 32 bits per the latched `sign`.
- `rdata` and `err` are registered outputs. They return to 0 on the RESP -> IDLE edge.
- `req` still high during RESP is not a new request. A new request is accepted only from IDLE, on the edge after RESP.

## Timing
- Reset values:
  - state IDLE;
  - `ack`=0, `err`=0, `rdata`=0, `busy`=0;
  - counter 0.
  - RAM contents are not reset.
- Latency: the request is accepted on edge E0; `ack` rises after edge E0+`WAIT_STATES`+1 and lasts one cycle.
- Throughput: one transaction per `WAIT_STATES`+3 cycles when `req` is held continuously.
- `busy` rises after E0 and falls together with `ack`.
- Reset mid-operation forces IDLE immediately, and no further response follows.
  - A store whose commit edge has not occurred is discarded.
  - A store already committed persists.
- Address wrap: a byte access at `2^ADDR_WIDTH - 1` is legal. A word access at byte 0 reaching the top of the address space cannot occur, because word accesses are aligned.

## Structure
- Shared package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum;
  - counter width constant (4).
- Sub-module `dmem_lane_align`, purely combinational:
  - from `addr[1:0]`, `size` and `sign`, produces the 4-bit byte-lane enable, the store-data lane shift, the load extraction/extension, and the misalignment flag.
- The top level holds the FSM, the counter, the input latches and the byte RAM array.

## Test plan
- Reset, then store word `0xDEADBEEF` @0x10, then load word @0x10 (`WAIT_STATES`=2) -> `ack` 3 cycles after acceptance, `rdata`=0xDEADBEEF, `err`=0.
- Load byte @0x13 with `sign`=1 -> 0xFFFFFFDE. Load half @0x10 with `sign`=0 -> 0x0000BEEF.
- Store byte `0x55` @0x11, then load word @0x10 -> 0xDEAD55EF (other lanes untouched).
- Half load @0x11 and word store @0x12 -> `err`=1, `ack`=1, `rdata`=0; a following load word @0x10 is unchanged.
- Build with `WAIT_STATES`=0, hold `req` continuously for 4 loads -> `ack` every 3rd cycle, exactly 4 pulses.
- Assert `rst` during WAIT of a store 0x12345678 @0x20 (previous value 0) -> no `ack`, outputs 0; a later load @0x20 returns 0.
